// File: rtl/cam_pattern_gen.sv
// rtl/cam_pattern_gen.sv - synthetic OV7670-style RGB565 camera bus source
// Inputs:  clk, rst (asynchronous, active-low), enable, pattern_sel[1:0]
// Outputs: pclk, href, vsync, data[7:0], busy, frame_done
module cam_pattern_gen #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       pclk,
  output logic       href,
  output logic       vsync,
  output logic [7:0] data,
  output logic       busy,
  output logic       frame_done
);

  localparam int L      = 2 * H_ACTIVE + H_BLANK;
  localparam int SW     = $clog2(L);
  localparam int LW_RAW = $clog2(VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES + 1);
  localparam int LW     = (LW_RAW < 4) ? 4 : LW_RAW;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [LW-1:0]   line_q, line_d;
  logic [1:0]      pat_q, pat_d;
  logic            pclk_q, pclk_d;
  logic            href_q, href_d;
  logic            vsync_q, vsync_d;
  logic [7:0]      data_q, data_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;

  logic [7:0]      px_x;
  logic [7:0]      bar;
  logic [15:0]     pix;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    line_d       = line_q;
    pat_d        = pat_q;
    pclk_d       = 1'b0;
    frame_done_d = 1'b0;
    href_d       = href_q;
    vsync_d      = vsync_q;
    data_d       = data_q;
    busy_d       = busy_q;
    px_x         = '0;
    bar          = '0;
    pix          = '0;

    if (state_q == S_IDLE) begin
      if (enable) begin
        state_d = S_VSYNC;
        slot_d  = '0;
        line_d  = '0;
        pat_d   = pattern_sel;
      end
    end else begin
      pclk_d = ~pclk_q;
      // pclk high means this edge ends the current slot
      if (pclk_q) begin
        if (slot_q != SW'(L - 1)) begin
          slot_d = slot_q + SW'(1);
        end else begin
          slot_d = '0;
          line_d = line_q + LW'(1);
          case (state_q)
            S_VSYNC: if (line_q == LW'(VSYNC_LINES - 1)) begin
              state_d = S_VBP;
              line_d  = '0;
            end
            S_VBP: if (line_q == LW'(VBP_LINES - 1)) begin
              state_d = S_ACTIVE;
              line_d  = '0;
            end
            S_ACTIVE: if (line_q == LW'(V_ACTIVE - 1)) begin
              state_d = S_VFP;
              line_d  = '0;
            end
            S_VFP: if (line_q == LW'(VFP_LINES - 1)) begin
              line_d       = '0;
              frame_done_d = 1'b1;
              if (enable) begin
                state_d = S_VSYNC;
                pat_d   = pattern_sel;
              end else begin
                state_d = S_IDLE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end

    // Bus outputs describe the slot being entered and hold between slot boundaries
    if (state_q == S_IDLE || pclk_q) begin
      px_x = 8'(slot_d >> 1);
      bar  = px_x / 8'(H_ACTIVE / 8);
      case (pat_d)
        2'd0: begin
          case (bar)
            8'd0:    pix = 16'hFFFF;
            8'd1:    pix = 16'hFFE0;
            8'd2:    pix = 16'h07FF;
            8'd3:    pix = 16'h07E0;
            8'd4:    pix = 16'hF81F;
            8'd5:    pix = 16'hF800;
            8'd6:    pix = 16'h001F;
            default: pix = 16'h0000;
          endcase
        end
        2'd1:    pix = {px_x[7:3], px_x[7:2], px_x[7:3]};
        2'd2:    pix = (px_x[3] ^ line_d[3]) ? 16'hFFFF : 16'h0000;
        default: pix = 16'hFFFF;
      endcase
      busy_d  = (state_d != S_IDLE);
      vsync_d = (state_d == S_VSYNC);
      href_d  = (state_d == S_ACTIVE) && (slot_d < SW'(2 * H_ACTIVE));
      data_d  = href_d ? (slot_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      line_q       <= '0;
      pat_q        <= '0;
      pclk_q       <= 1'b0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      data_q       <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      line_q       <= line_d;
      pat_q        <= pat_d;
      pclk_q       <= pclk_d;
      href_q       <= href_d;
      vsync_q      <= vsync_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pclk       = pclk_q;
  assign href       = href_q;
  assign vsync      = vsync_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
